// File: rtl/rr_arbiter.sv
// Round-robin arbiter over 2**N requesters with a bounded grant tenure.
// A holder releases on done, on dropping its request, or when its hold limit runs out.
module rr_arbiter #(
  parameter int unsigned N        = 4,
  parameter int unsigned MAX_HOLD = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [2**N-1:0]  req,
  input  logic             done,
  output logic [2**N-1:0]  grant,
  output logic [N-1:0]     grant_idx,
  output logic             grant_valid,
  output logic             timeout
);

  localparam int unsigned M        = 2**N;
  localparam int unsigned HCNT_W   = 8;
  localparam logic [HCNT_W-1:0] HOLD_MAX = HCNT_W'(MAX_HOLD);

  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_OWNED = 1'b1;

  logic [0:0]        state_q, state_d;
  logic [N-1:0]      ptr_q, ptr_d;
  logic [HCNT_W-1:0] hcnt_q, hcnt_d;
  logic [N-1:0]      grant_idx_d;
  logic              grant_valid_d;
  logic [M-1:0]      grant_d;
  logic              timeout_d;

  logic              holder_req;
  logic              hold_hit;
  logic              release_c;
  logic [N-1:0]      rel_ptr;
  logic [M-1:0]      masked_req;
  logic [N:0]        idle_pick;
  logic [N:0]        rel_pick;

  // First set bit of r scanning upward from p with wrap; returns {found, index}.
  function automatic logic [N:0] rr_pick(input logic [M-1:0] r, input logic [N-1:0] p);
    logic         found;
    logic [N-1:0] idx;
    logic [N-1:0] cand;
    found = 1'b0;
    idx   = '0;
    for (int i = 0; i < M; i++) begin
      cand = p + N'(i);
      if (!found && r[cand]) begin
        found = 1'b1;
        idx   = cand;
      end
    end
    return {found, idx};
  endfunction

  // Release detection and both arbitration candidates.
  always_comb begin
    holder_req = req[grant_idx];
    hold_hit   = (hcnt_q == HOLD_MAX);
    release_c  = done | ~holder_req | hold_hit;
    rel_ptr    = grant_idx + N'(1);
    masked_req = req & ~(M'(1) << grant_idx);
    idle_pick  = rr_pick(req, ptr_q);
    rel_pick   = rr_pick(masked_req, rel_ptr);
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d       = state_q;
    ptr_d         = ptr_q;
    hcnt_d        = hcnt_q;
    grant_idx_d   = grant_idx;
    grant_valid_d = grant_valid;
    timeout_d     = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (idle_pick[N]) begin
          state_d       = S_OWNED;
          grant_idx_d   = idle_pick[N-1:0];
          grant_valid_d = 1'b1;
          hcnt_d        = HCNT_W'(1);
        end else begin
          grant_idx_d   = '0;
          grant_valid_d = 1'b0;
        end
      end
      S_OWNED: begin
        if (release_c) begin
          ptr_d     = rel_ptr;
          // Timeout only when the limit alone forced the release.
          timeout_d = hold_hit & ~done & holder_req;
          if (rel_pick[N]) begin
            grant_idx_d   = rel_pick[N-1:0];
            grant_valid_d = 1'b1;
            hcnt_d        = HCNT_W'(1);
          end else begin
            state_d       = S_IDLE;
            grant_idx_d   = '0;
            grant_valid_d = 1'b0;
            hcnt_d        = '0;
          end
        end else begin
          hcnt_d = hcnt_q + HCNT_W'(1);
        end
      end
      default: begin
        state_d       = S_IDLE;
        grant_idx_d   = '0;
        grant_valid_d = 1'b0;
        hcnt_d        = '0;
      end
    endcase

    grant_d = grant_valid_d ? (M'(1) << grant_idx_d) : '0;
  end

  // State and output registers; reset dominates everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      ptr_q       <= '0;
      hcnt_q      <= '0;
      grant       <= '0;
      grant_idx   <= '0;
      grant_valid <= 1'b0;
      timeout     <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      hcnt_q      <= hcnt_d;
      grant       <= grant_d;
      grant_idx   <= grant_idx_d;
      grant_valid <= grant_valid_d;
      timeout     <= timeout_d;
    end
  end

endmodule

// File: tb/tb_rr_arbiter.sv
// Bench for rr_arbiter: directed scenarios plus randomized traffic against
// a cycle-level behavioural model of the round-robin rules.
module tb_rr_arbiter;

  localparam int M        = 16;
  localparam int MAX_HOLD = 16;

  logic          clk;
  logic          rst;
  logic [15:0]   req;
  logic          done;
  logic [15:0]   grant;
  logic [3:0]    grant_idx;
  logic          grant_valid;
  logic          timeout;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state.
  bit m_owned;
  int m_idx;
  int m_ptr;
  int m_hold;
  bit m_to;

  rr_arbiter #(.N(4), .MAX_HOLD(MAX_HOLD)) dut (
    .clk         (clk),
    .rst         (rst),
    .req         (req),
    .done        (done),
    .grant       (grant),
    .grant_idx   (grant_idx),
    .grant_valid (grant_valid),
    .timeout     (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int pick(input logic [15:0] r, input int from);
    for (int k = 0; k < M; k++) begin
      if (r[(from + k) % M]) return (from + k) % M;
    end
    return -1;
  endfunction

  task automatic model_update(input logic [15:0] r, input logic d, input logic rs);
    int nxt;
    logic [15:0] others;
    if (rs) begin
      m_owned = 0; m_idx = 0; m_ptr = 0; m_hold = 0; m_to = 0;
    end else if (!m_owned) begin
      m_to = 0;
      nxt  = pick(r, m_ptr);
      if (nxt >= 0) begin
        m_owned = 1; m_idx = nxt; m_hold = 1;
      end
    end else if (d || !r[m_idx] || m_hold == MAX_HOLD) begin
      m_to   = !d && r[m_idx] && (m_hold == MAX_HOLD);
      m_ptr  = (m_idx + 1) % M;
      others = r;
      others[m_idx] = 1'b0;
      nxt = pick(others, m_ptr);
      if (nxt >= 0) begin
        m_idx = nxt; m_hold = 1;
      end else begin
        m_owned = 0; m_idx = 0; m_hold = 0;
      end
    end else begin
      m_hold++;
      m_to = 0;
    end
  endtask

  // Apply inputs for one cycle, advance the model, compare all outputs.
  task automatic step(input logic [15:0] r, input logic d, input logic rs);
    logic [15:0] exp_grant;
    req = r; done = d; rst = rs;
    @(posedge clk);
    model_update(r, d, rs);
    #1;
    exp_grant = 16'h0;
    if (m_owned) exp_grant[m_idx] = 1'b1;
    check("grant",       grant,       exp_grant);
    check("grant_idx",   grant_idx,   m_owned ? m_idx : 0);
    check("grant_valid", grant_valid, m_owned);
    check("timeout",     timeout,     m_to);
  endtask

  task automatic do_reset();
    step(16'h0, 1'b0, 1'b1);
    step(16'h0, 1'b0, 1'b1);
  endtask

  initial begin
    int hold_cycles;
    logic [15:0] r;
    req = '0; done = 1'b0; rst = 1'b1;
    m_owned = 0; m_idx = 0; m_ptr = 0; m_hold = 0; m_to = 0;

    do_reset();
    check("reset_valid", grant_valid, 1'b0);
    step(16'h0, 1'b0, 1'b0);
    check("idle_stays", grant, 16'h0);

    // Reset mid-grant drops the grant immediately.
    step(16'h0020, 1'b0, 1'b0);
    check("r30_pre_idx", grant_idx, 5);
    step(16'h0020, 1'b0, 1'b0);
    step(16'h0020, 1'b0, 1'b1);
    check("r30_rst_grant", grant, 16'h0);
    check("r30_rst_valid", grant_valid, 1'b0);
    check("r30_rst_idx",   grant_idx, 0);
    step(16'h0020, 1'b0, 1'b1);
    step(16'h0020, 1'b0, 1'b0);
    check("r30_post_idx", grant_idx, 5);

    // Full request vector with done every cycle rotates without bubbles.
    do_reset();
    step(16'hFFFF, 1'b0, 1'b0);
    check("r31_first", grant_idx, 0);
    for (int i = 1; i <= 16; i++) begin
      step(16'hFFFF, 1'b1, 1'b0);
      check("r31_seq", grant_idx, i % 16);
      check("r31_valid", grant_valid, 1'b1);
    end

    // Wrap-around between requesters 0 and 15.
    do_reset();
    step(16'h8001, 1'b0, 1'b0);
    check("r32_g0", grant_idx, 0);
    step(16'h8001, 1'b1, 1'b0);
    check("r32_g15", grant_idx, 15);
    check("r32_nobubble", grant_valid, 1'b1);
    step(16'h8001, 1'b1, 1'b0);
    check("r32_wrap", grant_idx, 0);

    // Hold limit forces a timeout, one idle cycle, then regrant.
    do_reset();
    hold_cycles = 0;
    step(16'h0004, 1'b0, 1'b0);
    while (grant_valid && hold_cycles < 40) begin
      hold_cycles++;
      step(16'h0004, 1'b0, 1'b0);
    end
    check("r33_hold_len", hold_cycles, MAX_HOLD);
    check("r33_timeout", timeout, 1'b1);
    check("r33_idle", grant_valid, 1'b0);
    step(16'h0004, 1'b0, 1'b0);
    check("r33_regrant", grant_idx, 2);
    check("r33_to_clear", timeout, 1'b0);

    // Holder drops its request; next arbitration starts after it.
    do_reset();
    step(16'h0008, 1'b0, 1'b0);
    check("r34_g3", grant_idx, 3);
    step(16'h0000, 1'b0, 1'b0);
    check("r34_drop", grant, 16'h0);
    check("r34_noto", timeout, 1'b0);
    step(16'h0028, 1'b0, 1'b0);
    check("r34_ptr4", grant_idx, 5);

    // done coinciding with the hold limit is not a timeout.
    do_reset();
    step(16'h0006, 1'b0, 1'b0);
    for (int i = 1; i < MAX_HOLD; i++) step(16'h0006, 1'b0, 1'b0);
    check("r35_still_held", grant_idx, 1);
    step(16'h0006, 1'b1, 1'b0);
    check("r35_noto", timeout, 1'b0);
    check("r35_next", grant_idx, 2);

    // Randomized traffic against the model.
    do_reset();
    r = 16'h0;
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 9) < 3) r = 16'($urandom) & 16'($urandom) & 16'($urandom);
      step(r, ($urandom_range(0, 5) == 0), ($urandom_range(0, 299) == 0));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/rr_arbiter.md
RR_ARBITER -- requirements
Module: rr_arbiter

Interface
REQ-001 Parameter N, default 4: requester index width; requester count M = 2**N.
REQ-002 Parameter MAX_HOLD, default 16: maximum grant tenure in cycles, legal range 1..255.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  synchronous active-high reset, sampled on the rising edge of clk.
REQ-005 req  input  M  request vector; bit i = requester i wants the shared resource.
REQ-006 done  input  1  current holder releases the resource; ignored when no grant is active.
REQ-007 grant  output  M  registered one-hot grant vector; all zeros when idle.
REQ-008 grant_idx  output  N  registered binary index of the granted requester; 0 when idle.
REQ-009 grant_valid  output  1  registered; high exactly when grant is nonzero.
REQ-010 timeout  output  1  registered one-cycle pulse when a grant is force-revoked by MAX_HOLD.

Function
REQ-011 The arbiter SHALL implement two states, IDLE and OWNED, with a pointer ptr (N bits) and a hold counter hcnt (8 bits).
REQ-012 Arbitration SHALL select the first set bit of req scanning upward from ptr, wrapping from M-1 to 0.
REQ-013 In IDLE with req nonzero, the arbiter SHALL arbitrate and assert the grant on the next edge (1-cycle latency), enter OWNED, and load hcnt with 1.
REQ-014 In IDLE with req zero, the arbiter SHALL remain in IDLE with all outputs at their idle values.
REQ-015 grant SHALL always equal the one-hot decode of grant_idx while grant_valid is high, and SHALL be zero otherwise.
REQ-016 In OWNED, the grant SHALL be held unchanged while req[grant_idx] is high, done is low, and hcnt < MAX_HOLD; hcnt SHALL increment each such cycle.
REQ-017 A release event SHALL be any of: done high; req[grant_idx] low; or hcnt == MAX_HOLD.
REQ-018 On a release event, ptr SHALL become grant_idx+1 modulo M. In the same cycle, arbitration SHALL run with that new ptr over the current req with the releasing bit masked out.
REQ-019 If the masked arbitration finds a requester, the new grant SHALL appear on the next edge with no idle bubble, and hcnt SHALL reload to 1.
REQ-020 If the masked arbitration finds no requester, the next state SHALL be IDLE and grant SHALL go to zero on the next edge.
REQ-021 A releasing requester that is the only one requesting SHALL be regranted only after one IDLE cycle.
REQ-022 timeout SHALL pulse high for exactly the cycle following a release caused solely by hcnt == MAX_HOLD, with done low and req[grant_idx] high.
REQ-023 When done and hcnt == MAX_HOLD coincide, the release SHALL count as done and timeout SHALL stay low.
REQ-024 Changes to req bits other than the holder's SHALL NOT affect an active grant.
REQ-025 With MAX_HOLD = 1, every grant SHALL last exactly one cycle unless released earlier.

Reset
REQ-026 While rst is high at a clock edge, the next state SHALL be: IDLE, ptr = 0, hcnt = 0, grant = 0, grant_idx = 0, grant_valid = 0, timeout = 0.
REQ-027 Reset SHALL take priority over all other inputs, including mid-grant; any active grant SHALL be dropped on that edge.
REQ-028 Before the first rst edge the outputs are undefined; the bench SHALL apply rst for at least 2 cycles.
REQ-029 After reset release, the first arbitration SHALL use ptr = 0.

Verification
REQ-030 Drive rst high for 2 cycles mid-grant (grant_idx = 5). Required: grant = 0, grant_valid = 0, and grant_idx = 0 on the first reset edge. Then apply req = 16'h0020: grant_idx = 5 one cycle later.
REQ-031 Hold req = 16'hFFFF and pulse done every cycle after each grant. Required: grant_idx sequence 0,1,2,...,15,0 with no idle cycles between grants.
REQ-032 Apply req = 16'h8001 with ptr = 0. Grant 0, then pulse done. Required: next grant = 15 with no bubble. Then pulse done again: next grant = 0, showing wrap-around.
REQ-033 Apply req = 16'h0004 held high with done low and MAX_HOLD = 16. Required: grant held 16 cycles, then timeout pulses one cycle, grant drops for one IDLE cycle, and grant_idx 2 is regranted.
REQ-034 Grant requester 3 and deassert req[3] with req = 16'h0000 otherwise. Required: grant = 0 next cycle, state IDLE, timeout = 0, and the next arbitration starts from ptr = 4.
REQ-035 Assert done on the same cycle hcnt reaches MAX_HOLD. Required: release occurs and timeout stays 0.
